leb128_stream_decoder: RTL and testbench



---
 rtl/leb128_stream_decoder_if.sv | 29 ++
 rtl/leb128_stream_decoder.sv | 121 ++++++++++++
 tb/tb_leb128_stream_decoder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/leb128_stream_decoder_if.sv
// Byte-in / word-out handshake bundle for the LEB128 stream decoder.
// The master modport is the surrounding system: byte producer plus result consumer.
// The slave modport is the decoder itself.
interface leb128_stream_decoder_if #(
   parameter int N = 64
);
   localparam int MB = N / 7 + 1;
   localparam int LW = $clog2(MB + 1);

   logic          signed_mode;
   logic          s_valid;
   logic          s_ready;
   logic [7:0]    s_data;
   logic          m_valid;
   logic          m_ready;
   logic [N-1:0]  m_data;
   logic [LW-1:0] m_len;
   logic          m_err;

   modport master (
      output signed_mode, s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_len, m_err
   );

   modport slave (
      input  signed_mode, s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_len, m_err
   );
endinterface

// File: rtl/leb128_stream_decoder.sv
// Byte-serial ULEB128/SLEB128 decoder; one decoded N-bit word per frame with length and error flag.
// Latency: result valid one cycle after the terminating byte is accepted.
// Backpressure: s_ready drops while a result is held un-accepted; SKIP always accepts.
module leb128_stream_decoder #(
   parameter int N = 64
) (
   input logic                    clk,
   input logic                    rst_n,
   leb128_stream_decoder_if.slave bus
);
   localparam int MB = N / 7 + 1;
   localparam int LW = $clog2(MB + 1);
   // Wide enough to hold every payload bit of a maximal frame, so the
   // out-of-range bits of the last byte can be inspected before truncation.
   localparam int W  = 7 * MB;

   typedef enum logic {RUN, SKIP} state_t;

   state_t        state;
   logic [LW-1:0] cnt;
   logic [N-1:0]  acc;
   logic          mode_q;
   logic          m_valid_q;
   logic [N-1:0]  m_data_q;
   logic [LW-1:0] m_len_q;
   logic          m_err_q;

   logic          s_ready;
   logic          accept;
   logic          glue;
   logic          last;
   logic          mode_cur;
   int            shamt;
   logic [W-1:0]  wide;
   logic [N-1:0]  ext;
   logic [N-1:0]  value;
   logic [W-N-1:0] hi;
   logic          range_bad;

   // RUN only stalls when a finished result is still waiting; SKIP never stalls.
   assign s_ready = (state == SKIP) || !m_valid_q || bus.m_ready;
   assign accept  = bus.s_valid && s_ready;

   assign bus.s_ready = s_ready;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign bus.m_len   = m_len_q;
   assign bus.m_err   = m_err_q;

   // Merge the incoming payload into the accumulator and derive the frame-end value and error.
   always_comb begin
      shamt     = 7 * int'(cnt);
      glue      = bus.s_data[7];
      last      = (cnt == LW'(MB - 1));
      // Mode comes straight from the pin on the first byte, from the latch afterwards.
      mode_cur  = (cnt == '0) ? bus.signed_mode : mode_q;
      wide      = W'(acc) | (W'(bus.s_data[6:0]) << shamt);
      // Bits above the last payload chunk; a shift past N leaves nothing to extend.
      ext       = {N{1'b1}} << (shamt + 7);
      value     = wide[N-1:0];
      if (mode_cur && bus.s_data[6]) begin
         value = value | ext;
      end
      hi        = wide[W-1:N];
      range_bad = 1'b0;
      if (last) begin
         if (mode_cur) begin
            range_bad = (hi != {(W-N){value[N-1]}});
         end else begin
            range_bad = (hi != '0);
         end
      end
   end

   // Frame FSM, accumulator and registered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         cnt       <= '0;
         acc       <= '0;
         mode_q    <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_len_q   <= '0;
         m_err_q   <= 1'b0;
      end else begin
         if (m_valid_q && bus.m_ready) begin
            m_valid_q <= 1'b0;
         end
         if (accept) begin
            case (state)
               RUN: begin
                  if (cnt == '0) begin
                     mode_q <= bus.signed_mode;
                  end
                  if (!glue || last) begin
                     // Terminating byte: load result (overrides the consume above).
                     m_valid_q <= 1'b1;
                     m_data_q  <= value;
                     m_len_q   <= cnt + LW'(1);
                     m_err_q   <= (glue && last) || range_bad;
                     cnt       <= '0;
                     acc       <= '0;
                     // Over-long frame: drop the rest of it up to the next glue=0 byte.
                     state     <= (glue && last) ? SKIP : RUN;
                  end else begin
                     acc <= wide[N-1:0];
                     cnt <= cnt + LW'(1);
                  end
               end
               SKIP: begin
                  if (!glue) begin
                     state <= RUN;
                  end
               end
               default: state <= RUN;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_leb128_stream_decoder.sv
// Self-checking bench for leb128_stream_decoder (N=64).
// Table of whole frames plus hand-written over-long, backpressure and reset sequences.
// Expected results go to a scoreboard queue and are compared as results are accepted.
module tb_leb128_stream_decoder;
   localparam int N  = 64;
   localparam int MB = N / 7 + 1;
   localparam int LW = $clog2(MB + 1);

   typedef struct {
      logic         mode;
      int           n;
      logic [79:0]  bs;     // byte i at bs[8*i +: 8]
      logic [63:0]  d;
      int           len;
      logic         err;
   } vec_t;

   typedef struct {
      logic [63:0]   d;
      logic [LW-1:0] len;
      logic          err;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   exp_t sb[$];
   vec_t vecs[12];

   leb128_stream_decoder_if #(.N(N)) bus ();

   leb128_stream_decoder #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endfunction

   function automatic vec_t mkv(input logic mode, input int n, input logic [79:0] bs,
                                input logic [63:0] d, input int len, input logic err);
      vec_t v;
      v.mode = mode; v.n = n; v.bs = bs; v.d = d; v.len = len; v.err = err;
      return v;
   endfunction

   function automatic void push_exp(input logic [63:0] d, input int len, input logic err);
      exp_t e;
      e.d = d; e.len = LW'(len); e.err = err;
      sb.push_back(e);
   endfunction

   // Scoreboard: compare every result as it is handed over.
   always @(negedge clk) begin
      if (rst_n && bus.m_valid && bus.m_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result actual=%h required=none", bus.m_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_data", bus.m_data, e.d);
            chk("sb_len", 64'(bus.m_len), 64'(e.len));
            chk("sb_err", 64'(bus.m_err), 64'(e.err));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic md, output int waited);
      bus.s_valid     = 1'b1;
      bus.s_data      = b;
      bus.signed_mode = md;
      waited = 0;
      forever begin
         @(negedge clk);
         if (bus.s_ready) break;
         waited++;
         if (waited > 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=s_ready_low required=accept");
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while ((sb.size() != 0 || bus.m_valid) && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc >= 200) begin
         total++;
         bad++;
         $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
      end
   endtask

   initial begin
      int w;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.s_valid     = 1'b0;
      bus.s_data      = 8'h00;
      bus.signed_mode = 1'b0;
      bus.m_ready     = 1'b1;

      vecs[0]  = mkv(1'b0, 3,  80'h26_8E_E5, 64'd624485, 3, 1'b0);
      vecs[1]  = mkv(1'b1, 3,  80'h78_BB_C0, -64'sd123456, 3, 1'b0);
      vecs[2]  = mkv(1'b1, 1,  80'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
      vecs[3]  = mkv(1'b0, 1,  80'h7F, 64'd127, 1, 1'b0);
      vecs[4]  = mkv(1'b0, 10, 80'h01_80808080_80808080_80, 64'h8000_0000_0000_0000, 10, 1'b0);
      vecs[5]  = mkv(1'b0, 10, 80'h02_80808080_80808080_80, 64'h0, 10, 1'b1);
      vecs[6]  = mkv(1'b1, 10, 80'h7F_80808080_80808080_80, 64'h8000_0000_0000_0000, 10, 1'b0);
      vecs[7]  = mkv(1'b1, 10, 80'h01_80808080_80808080_80, 64'h8000_0000_0000_0000, 10, 1'b1);
      vecs[8]  = mkv(1'b1, 1,  80'h02, 64'd2, 1, 1'b0);
      vecs[9]  = mkv(1'b0, 2,  80'h7F_FF, 64'h3FFF, 2, 1'b0);
      vecs[10] = mkv(1'b1, 2,  80'h40_80, 64'hFFFF_FFFF_FFFF_E000, 2, 1'b0);
      vecs[11] = mkv(1'b0, 2,  80'h40_80, 64'h2000, 2, 1'b0);

      // Reset values.
      #12;
      chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
      chk("rst_m_data", bus.m_data, 64'd0);
      chk("rst_m_len", 64'(bus.m_len), 64'd0);
      chk("rst_m_err", 64'(bus.m_err), 64'd0);
      chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Table of frames; signed_mode is inverted after the first byte to prove it is latched.
      for (int i = 0; i < 12; i++) begin
         push_exp(vecs[i].d, vecs[i].len, vecs[i].err);
         for (int k = 0; k < vecs[i].n; k++) begin
            send_byte(vecs[i].bs[8*k +: 8], (k == 0) ? vecs[i].mode : ~vecs[i].mode, w);
         end
         chk($sformatf("latency_v%0d", i), 64'(bus.m_valid), 64'd1);
      end
      drain();

      // Over-long frame, then skipped bytes accepted even with the result held.
      push_exp(64'hFFFF_FFFF_FFFF_FFFF, 10, 1'b1);
      for (int k = 0; k < 10; k++) send_byte(8'hFF, 1'b0, w);
      bus.m_ready = 1'b0;
      send_byte(8'hFF, 1'b0, w);
      chk("skip_ff_nowait", 64'(w), 64'd0);
      send_byte(8'h01, 1'b0, w);
      chk("skip_01_nowait", 64'(w), 64'd0);
      chk("skip_held_valid", 64'(bus.m_valid), 64'd1);
      chk("skip_held_len", 64'(bus.m_len), 64'd10);
      bus.m_ready = 1'b1;
      push_exp(64'd5, 1, 1'b0);
      send_byte(8'h05, 1'b0, w);

      // Backpressure: result 5 held, byte 03 stalls, then flows with no bubble.
      bus.m_ready = 1'b0;
      push_exp(64'd3, 1, 1'b0);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h03;
      bus.signed_mode = 1'b0;
      @(negedge clk);
      chk("bp_s_ready_low", 64'(bus.s_ready), 64'd0);
      chk("bp_data_hold1", bus.m_data, 64'd5);
      @(posedge clk);
      #1;
      chk("bp_data_hold2", bus.m_data, 64'd5);
      chk("bp_valid_hold", 64'(bus.m_valid), 64'd1);
      bus.m_ready = 1'b1;
      #1;
      chk("bp_s_ready_high", 64'(bus.s_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      chk("bp_nogap_valid", 64'(bus.m_valid), 64'd1);
      chk("bp_nogap_data", bus.m_data, 64'd3);
      drain();

      // Reset in the middle of a frame discards it.
      send_byte(8'hE5, 1'b0, w);
      send_byte(8'h8E, 1'b0, w);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_valid", 64'(bus.m_valid), 64'd0);
      chk("mid_rst_data", bus.m_data, 64'd0);
      chk("mid_rst_len", 64'(bus.m_len), 64'd0);
      chk("mid_rst_err", 64'(bus.m_err), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_exp(64'd42, 1, 1'b0);
      send_byte(8'h2A, 1'b0, w);
      drain();

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
